// File: rtl/gf180mcu_fd_sc_mcu7t5v0__bist_pkg.sv
// Shared definitions for the gf180mcu 3-input cell self-test drivers.
// Contents: FSM state encoding, vector width/type, truth tables for the
// common 3-input families (bit index = {B,A2,A1}), and a truth-table lookup helper.
package gf180mcu_fd_sc_mcu7t5v0__bist_pkg;

  localparam int unsigned VEC_W = 3;

  typedef logic [VEC_W-1:0] vec_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_FIN
  } bist_state_e;

  // Expected ZN for each {B,A2,A1} input vector.
  localparam logic [7:0] TT_OAI21 = 8'h1F;  // !((A1|A2)&B)
  localparam logic [7:0] TT_AOI21 = 8'h07;  // !((A1&A2)|B)
  localparam logic [7:0] TT_NAND3 = 8'h7F;  // !(A1&A2&B)
  localparam logic [7:0] TT_NOR3  = 8'h01;  // !(A1|A2|B)

  function automatic logic tt_bit(input logic [7:0] tt, input vec_t vec);
    return tt[vec];
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__bist_drv3_if.sv
// Harness-side bus of the 3-input cell self-test driver.
// Run control (START/BUSY/DONE), result reporting (FAIL/ERR_CNT/FIRST_FAIL_VEC)
// and the cell-side stimulus/response (A1/A2/B out, ZN back).
// master: harness / cell model side; slave: the BIST driver.
interface gf180mcu_fd_sc_mcu7t5v0__bist_drv3_if
  import gf180mcu_fd_sc_mcu7t5v0__bist_pkg::*;
#(
  parameter int unsigned ERR_W = 4
);
  logic             START;
  logic             ZN;
  logic             A1;
  logic             A2;
  logic             B;
  logic             BUSY;
  logic             DONE;
  logic             FAIL;
  logic [ERR_W-1:0] ERR_CNT;
  vec_t             FIRST_FAIL_VEC;

  modport master (
    output START, ZN,
    input  A1, A2, B, BUSY, DONE, FAIL, ERR_CNT, FIRST_FAIL_VEC
  );

  modport slave (
    input  START, ZN,
    output A1, A2, B, BUSY, DONE, FAIL, ERR_CNT, FIRST_FAIL_VEC
  );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__bist_acc.sv
// Result accumulator for the 3-input cell self-test driver.
// Compares the sampled cell output against the expected truth-table bit,
// keeps a saturating mismatch count, a sticky fail flag and the first
// failing vector.
// Ports: clk, rst_n (async active-low), clear (start of run), sample (compare
// strobe), vec (vector being sampled), zn (cell output), exp_zn (expected),
// err_cnt / fail / first_fail_vec (results).
module gf180mcu_fd_sc_mcu7t5v0__bist_acc
  import gf180mcu_fd_sc_mcu7t5v0__bist_pkg::*;
#(
  parameter int unsigned ERR_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             sample,
  input  vec_t             vec,
  input  logic             zn,
  input  logic             exp_zn,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail,
  output vec_t             first_fail_vec
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt        <= '0;
      fail           <= 1'b0;
      first_fail_vec <= '0;
    end else if (clear) begin
      err_cnt        <= '0;
      fail           <= 1'b0;
      first_fail_vec <= '0;
    end else if (sample) begin
      // Written as match/else so an unknown ZN falls into the mismatch branch.
      if (zn == exp_zn) begin
      end else begin
        if (err_cnt != '1) begin
          err_cnt <= err_cnt + ERR_W'(1);
        end
        fail <= 1'b1;
        if (!fail) begin
          first_fail_vec <= vec;
        end
      end
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__bist_drv3.sv
// Self-test driver for 3-input combinational cells (oai21 family by default).
// Walks all 8 {B,A2,A1} vectors PASSES times, holding each SETTLE+1 cycles and
// sampling ZN on the last edge of the hold window against truth table TT.
// Ports: CLK (rising edge), RN (async active-low reset), bus (slave side of the
// driver interface: START/ZN in; A1/A2/B/BUSY/DONE/FAIL/ERR_CNT/FIRST_FAIL_VEC
// out), VDD/VSS supply pins with no logic function.
module gf180mcu_fd_sc_mcu7t5v0__bist_drv3
  import gf180mcu_fd_sc_mcu7t5v0__bist_pkg::*;
#(
  parameter logic [7:0]  TT     = TT_OAI21,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned PASSES = 1,
  parameter int unsigned ERR_W  = 4
) (
  input  logic CLK,
  input  logic RN,
  gf180mcu_fd_sc_mcu7t5v0__bist_drv3_if.slave bus,
  inout  wire  VDD,
  inout  wire  VSS
);

  bist_state_e      state;
  vec_t             vec;
  logic [7:0]       pass_cnt;
  logic [3:0]       settle_cnt;
  logic             busy;
  logic             done;
  logic             acc_clear;
  logic             acc_sample;
  logic [ERR_W-1:0] err_cnt;
  logic             fail;
  vec_t             first_fail_vec;
  logic             unused_supplies;

  assign unused_supplies = &{1'b0, VDD, VSS};

  assign acc_clear  = (state == ST_IDLE) && bus.START;
  assign acc_sample = (state == ST_DRIVE) && (settle_cnt == '0);

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state      <= ST_IDLE;
      vec        <= '0;
      pass_cnt   <= '0;
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.START) begin
            state      <= ST_DRIVE;
            vec        <= '0;
            pass_cnt   <= '0;
            settle_cnt <= 4'(SETTLE);
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        ST_DRIVE: begin
          if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - 4'd1;
          end else begin
            // Sampling edge also advances the vector; 7 wraps to 0 so the
            // cell inputs are already back at 0 once the last pass ends.
            settle_cnt <= 4'(SETTLE);
            vec        <= vec + 3'd1;
            if (vec == 3'd7) begin
              if (pass_cnt == 8'(PASSES - 1)) begin
                state <= ST_FIN;
              end else begin
                pass_cnt <= pass_cnt + 8'd1;
              end
            end
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
          vec   <= '0;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  gf180mcu_fd_sc_mcu7t5v0__bist_acc #(
    .ERR_W (ERR_W)
  ) u_acc (
    .clk            (CLK),
    .rst_n          (RN),
    .clear          (acc_clear),
    .sample         (acc_sample),
    .vec            (vec),
    .zn             (bus.ZN),
    .exp_zn         (tt_bit(TT, vec)),
    .err_cnt        (err_cnt),
    .fail           (fail),
    .first_fail_vec (first_fail_vec)
  );

  assign bus.A1             = vec[0];
  assign bus.A2             = vec[1];
  assign bus.B              = vec[2];
  assign bus.BUSY           = busy;
  assign bus.DONE           = done;
  assign bus.FAIL           = fail;
  assign bus.ERR_CNT        = err_cnt;
  assign bus.FIRST_FAIL_VEC = first_fail_vec;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__bist_drv3.sv
// Bench for the 3-input cell self-test driver: two instances (defaults, and
// ERR_W=2/PASSES=2), a cell model on ZN, and a scoreboard of expected run results.
module tb_gf180mcu_fd_sc_mcu7t5v0__bist_drv3;

  typedef struct {
    int unsigned lat;
    int unsigned errs;
    int unsigned fail;
    int unsigned ffv;
  } exp_t;

  logic clk;
  logic rn;
  int   zn_mode;  // 0 ideal oai21, 1 stuck-1, 2 stuck-0
  wire  vdd = 1'b1;
  wire  vss = 1'b0;

  int unsigned n_cmp;
  int unsigned n_err;
  exp_t        sb_q[$];

  gf180mcu_fd_sc_mcu7t5v0__bist_drv3_if #(.ERR_W(4)) bus0 ();
  gf180mcu_fd_sc_mcu7t5v0__bist_drv3_if #(.ERR_W(2)) bus1 ();

  assign bus0.ZN = (zn_mode == 0) ? ~((bus0.A1 | bus0.A2) & bus0.B) : (zn_mode == 1);
  assign bus1.ZN = 1'b0;

  gf180mcu_fd_sc_mcu7t5v0__bist_drv3 u_dut0 (
    .CLK (clk),
    .RN  (rn),
    .bus (bus0),
    .VDD (vdd),
    .VSS (vss)
  );

  gf180mcu_fd_sc_mcu7t5v0__bist_drv3 #(
    .ERR_W  (2),
    .PASSES (2)
  ) u_dut1 (
    .CLK (clk),
    .RN  (rn),
    .bus (bus1),
    .VDD (vdd),
    .VSS (vss)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic read_dut(input int which, output int unsigned busy, output int unsigned done,
                          output int unsigned fail, output int unsigned errs,
                          output int unsigned ffv, output int unsigned drv);
    if (which == 0) begin
      busy = bus0.BUSY; done = bus0.DONE; fail = bus0.FAIL;
      errs = bus0.ERR_CNT; ffv = bus0.FIRST_FAIL_VEC;
      drv  = {bus0.B, bus0.A2, bus0.A1};
    end else begin
      busy = bus1.BUSY; done = bus1.DONE; fail = bus1.FAIL;
      errs = bus1.ERR_CNT; ffv = bus1.FIRST_FAIL_VEC;
      drv  = {bus1.B, bus1.A2, bus1.A1};
    end
  endtask

  // Reference: walk the vectors, apply the ZN model, compare with the oai21 table.
  function automatic exp_t model(input int mode, input int passes, input int err_w);
    exp_t        e;
    logic [7:0]  tt;
    logic [2:0]  vv;
    logic        zn;
    int unsigned cap;
    e   = '{default: 0};
    tt  = 8'h1F;
    cap = (1 << err_w) - 1;
    for (int p = 0; p < passes; p++) begin
      for (int v = 0; v < 8; v++) begin
        vv = v[2:0];
        zn = (mode == 0) ? !((vv[0] | vv[1]) & vv[2]) : (mode == 1);
        if (zn != tt[v]) begin
          if (e.errs < cap) e.errs++;
          if (e.fail == 0) e.ffv = v;
          e.fail = 1;
        end
      end
    end
    e.lat = 8 * (2 + 1) * passes + 1;
    return e;
  endfunction

  task automatic set_start(input int which, input logic val);
    if (which == 0) bus0.START = val;
    else bus1.START = val;
  endtask

  task automatic do_run(input int which, input int mode, input int glitch_edge, input string name);
    exp_t        e;
    int unsigned edges;
    int unsigned busy, done, fail, errs, ffv, drv;
    bit          seen;
    e = (which == 0) ? model(mode, 1, 4) : model(mode, 2, 2);
    sb_q.push_back(e);
    @(negedge clk);
    zn_mode = mode;
    set_start(which, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_start(which, 1'b0);
    read_dut(which, busy, done, fail, errs, ffv, drv);
    check_eq({name, "_busy_start"}, busy, 1);
    check_eq({name, "_done_cleared"}, done, 0);
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 400) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      set_start(which, (glitch_edge != 0) && (edges == glitch_edge - 1));
      read_dut(which, busy, done, fail, errs, ffv, drv);
      seen = (done == 1);
    end
    check_eq({name, "_done_seen"}, seen, 1);
    e = sb_q.pop_front();
    check_eq({name, "_latency"}, edges, e.lat);
    check_eq({name, "_err_cnt"}, errs, e.errs);
    check_eq({name, "_fail"}, fail, e.fail);
    check_eq({name, "_first_fail"}, ffv, e.ffv);
    check_eq({name, "_busy_end"}, busy, 0);
    check_eq({name, "_drv_end"}, drv, 0);
    repeat (3) @(negedge clk);
    read_dut(which, busy, done, fail, errs, ffv, drv);
    check_eq({name, "_done_held"}, done, 1);
    check_eq({name, "_err_held"}, errs, e.errs);
  endtask

  initial begin
    int unsigned busy, done, fail, errs, ffv, drv;
    n_cmp      = 0;
    n_err      = 0;
    rn         = 1'b0;
    zn_mode    = 0;
    bus0.START = 1'b0;
    bus1.START = 1'b0;
    #12;
    for (int w = 0; w < 2; w++) begin
      read_dut(w, busy, done, fail, errs, ffv, drv);
      check_eq("reset_outputs", busy + done + fail + errs + ffv + drv, 0);
    end
    @(negedge clk);
    rn = 1'b1;

    do_run(0, 0, 0, "ideal");
    do_run(0, 1, 0, "stuck1");
    do_run(0, 2, 0, "stuck0");
    do_run(0, 1, 10, "restart_ignored");
    do_run(1, 2, 0, "sat_2pass");

    // Abort mid-run with results partially accumulated.
    @(negedge clk);
    zn_mode    = 2;
    bus0.START = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus0.START = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    read_dut(0, busy, done, fail, errs, ffv, drv);
    check_eq("pre_abort_err_cnt", errs, 4);
    check_eq("pre_abort_drv", drv, 4);
    rn = 1'b0;
    #1;
    read_dut(0, busy, done, fail, errs, ffv, drv);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_results", fail + errs + ffv, 0);
    check_eq("abort_drv", drv, 0);
    @(negedge clk);
    rn = 1'b1;
    repeat (30) @(negedge clk);
    read_dut(0, busy, done, fail, errs, ffv, drv);
    check_eq("no_done_after_abort", done, 0);
    do_run(0, 0, 0, "post_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
